// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline boundary register with valid/ready flow control.
// Holds the EX-stage control bits and data for the data-memory stage.
// SKID=1 adds a second entry so that in_ready can come straight from a flop.
// Flush kills every held entry.
// Control outputs are forced to 0 whenever no beat is valid.
// reg_write is suppressed when the destination register is register 0.
module ex_mem_stage_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int SKID       = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_read_e,
    input  logic                  mem_to_reg_e,
    input  logic                  mem_write_e,
    input  logic                  reg_write_e,
    input  logic [DATA_W-1:0]     alu_result_e,
    input  logic [DATA_W-1:0]     write_data_e,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  mem_read_m,
    output logic                  mem_to_reg_m,
    output logic                  mem_write_m,
    output logic                  reg_write_m,
    output logic [DATA_W-1:0]     alu_result_m,
    output logic [DATA_W-1:0]     write_data_m,
    output logic [REG_ADDR_W-1:0] write_reg_m
);

    typedef struct packed {
        logic                  valid;
        logic                  mem_read;
        logic                  mem_to_reg;
        logic                  mem_write;
        logic                  reg_write;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     write_data;
        logic [REG_ADDR_W-1:0] write_reg;
    } entry_t;

    // The main entry drives the MEM side.
    // The skid entry catches one beat while the main entry is stalled.
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    entry_t in_beat;
    logic   accept;
    logic   drain;

    // With the skid buffer, in_ready depends only on a flop.
    // Without it, in_ready passes through out_ready.
    assign in_ready = (SKID != 0) ? ~s_q.valid : (out_ready | ~m_q.valid);
    assign accept   = in_valid & in_ready;
    assign drain    = m_q.valid & out_ready;

    // Pack the incoming beat; register 0 is never a write target
    always_comb begin
        in_beat            = '0;
        in_beat.valid      = 1'b1;
        in_beat.mem_read   = mem_read_e;
        in_beat.mem_to_reg = mem_to_reg_e;
        in_beat.mem_write  = mem_write_e;
        in_beat.reg_write  = reg_write_e & (write_reg_e != '0);
        in_beat.alu_result = alu_result_e;
        in_beat.write_data = write_data_e;
        in_beat.write_reg  = write_reg_e;
    end

    // Next-state for both entries; flush wins over every handshake
    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of inferred latches.
        m_d = m_q;
        s_d = s_q;
        if (flush) begin
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (SKID != 0) begin
            if (drain && s_q.valid) begin
                // in_ready is low while the skid entry is full, so no accept can collide here
                m_d       = s_q;
                s_d.valid = 1'b0;
            end else if (accept && (!m_q.valid || drain)) begin
                m_d = in_beat;
            end else if (accept) begin
                s_d = in_beat;
            end else if (drain) begin
                m_d.valid = 1'b0;
            end
        end else begin
            if (accept) begin
                m_d = in_beat;
            end else if (drain) begin
                m_d.valid = 1'b0;
            end
        end
    end

    // Entry state flops, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the data payload is reset as well so that every *_m output reads 0 out of reset.
        if (!rst_n) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values.
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    // Control bits qualified by valid so that bubbles never carry stale controls
    assign out_valid    = m_q.valid;
    assign mem_read_m   = m_q.mem_read   & m_q.valid;
    assign mem_to_reg_m = m_q.mem_to_reg & m_q.valid;
    assign mem_write_m  = m_q.mem_write  & m_q.valid;
    assign reg_write_m  = m_q.reg_write  & m_q.valid;
    assign alu_result_m = m_q.alu_result;
    assign write_data_m = m_q.write_data;
    assign write_reg_m  = m_q.write_reg;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg.
// Index 0 is the SKID=0 instance with DATA_W=64.
// Index 1 is the SKID=1 instance with DATA_W=32.
// Expected beats are queued on accept and compared when the MEM side drains them.
module tb_ex_mem_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        mr_e, mtr_e, mw_e, rw_e;
    logic [63:0] alu_e, wd_e;
    logic [4:0]  wr_e;
    logic        mr_m [2];
    logic        mtr_m [2];
    logic        mw_m [2];
    logic        rw_m [2];
    logic [4:0]  wr_m [2];
    logic [63:0] alu_m0, wd_m0;
    logic [31:0] alu_m1, wd_m1;

    typedef struct packed {
        logic        mr;
        logic        mtr;
        logic        mw;
        logic        rw;
        logic [63:0] alu;
        logic [63:0] wd;
        logic [4:0]  wr;
    } beat_t;

    beat_t sb0[$];
    beat_t sb1[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    ex_mem_stage_reg #(.DATA_W(64), .REG_ADDR_W(5), .SKID(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .mem_read_e(mr_e), .mem_to_reg_e(mtr_e), .mem_write_e(mw_e), .reg_write_e(rw_e),
        .alu_result_e(alu_e), .write_data_e(wd_e), .write_reg_e(wr_e),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .mem_read_m(mr_m[0]), .mem_to_reg_m(mtr_m[0]), .mem_write_m(mw_m[0]), .reg_write_m(rw_m[0]),
        .alu_result_m(alu_m0), .write_data_m(wd_m0), .write_reg_m(wr_m[0])
    );

    ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(5), .SKID(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .mem_read_e(mr_e), .mem_to_reg_e(mtr_e), .mem_write_e(mw_e), .reg_write_e(rw_e),
        .alu_result_e(alu_e[31:0]), .write_data_e(wd_e[31:0]), .write_reg_e(wr_e),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .mem_read_m(mr_m[1]), .mem_to_reg_m(mtr_m[1]), .mem_write_m(mw_m[1]), .reg_write_m(rw_m[1]),
        .alu_result_m(alu_m1), .write_data_m(wd_m1), .write_reg_m(wr_m[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t get_out(input int i);
        beat_t b;
        b.mr  = mr_m[i];
        b.mtr = mtr_m[i];
        b.mw  = mw_m[i];
        b.rw  = rw_m[i];
        b.alu = (i == 0) ? alu_m0 : {32'h0, alu_m1};
        b.wd  = (i == 0) ? wd_m0  : {32'h0, wd_m1};
        b.wr  = wr_m[i];
        return b;
    endfunction

    function automatic int sb_size(input int i);
        return (i == 0) ? sb0.size() : sb1.size();
    endfunction

    task automatic clear_sb(input int i);
        if (i == 0) sb0.delete();
        else        sb1.delete();
    endtask

    // Monitor: compare drained beats in order; bubbles must carry zero controls
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!out_valid[i]) begin
                check("bubble_ctrl", {mr_m[i], mtr_m[i], mw_m[i], rw_m[i]}, 4'b0000);
            end else if (out_ready[i]) begin
                if (sb_size(i) == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat[%0d]: got alu=%0h expected no beat", i, get_out(i).alu);
                end else begin
                    beat_t e;
                    e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                    check("beat", get_out(i), e);
                end
            end
        end
    end

    // Offer one beat on instance idx and wait (bounded) for it to be accepted
    task automatic send(input int idx, input logic [3:0] ctl, input logic [63:0] alu,
                        input logic [63:0] wd, input logic [4:0] wr, input logic exp_rw);
        int    n;
        beat_t e;
        {mr_e, mtr_e, mw_e, rw_e} = ctl;
        alu_e = alu;
        wd_e  = wd;
        wr_e  = wr;
        in_valid[idx] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[idx] && n < 50);
        if (!in_ready[idx]) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout[%0d]: got in_ready=0 expected 1 within 50 cycles", idx);
            in_valid[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        e.mr  = ctl[3];
        e.mtr = ctl[2];
        e.mw  = ctl[1];
        e.rw  = exp_rw;
        e.alu = (idx == 1) ? {32'h0, alu[31:0]} : alu;
        e.wd  = (idx == 1) ? {32'h0, wd[31:0]}  : wd;
        e.wr  = wr;
        if (idx == 0) sb0.push_back(e);
        else          sb1.push_back(e);
    endtask

    task automatic wait_empty(input int idx);
        int n = 0;
        while (sb_size(idx) > 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", sb_size(idx), 0);
    endtask

    task automatic run_plan(input int idx);
        int c0;
        // Streaming with out_ready high
        out_ready[idx] = 1'b1;
        c0 = cyc;
        send(idx, 4'b0001, 64'h10, 64'hDEAD_BEEF, 5'd5, 1'b1);
        check("lat_ctrl", {out_valid[idx], rw_m[idx], wr_m[idx]}, {1'b1, 1'b1, 5'd5});
        check("lat_alu", get_out(idx).alu, 64'h10);
        send(idx, 4'b1101, 64'h20, 64'h1111, 5'd7, 1'b1);
        send(idx, 4'b0010, 64'h30, 64'h2222, 5'd9, 1'b0);
        check("stream_cycles", cyc - c0, 3);
        send(idx, 4'b0001, 64'hA5A5_0000_0000_0001, 64'h0123_4567_89AB_CDEF, 5'd31, 1'b1);
        wait_empty(idx);

        // Register-0 write guard
        send(idx, 4'b1101, 64'h44, 64'h55, 5'd0, 1'b0);
        check("reg0_guard", {mr_m[idx], mtr_m[idx], mw_m[idx], rw_m[idx]}, 4'b1100);
        wait_empty(idx);

        // Backpressure: fill, hold the next beat in EX, then release
        out_ready[idx] = 1'b0;
        send(idx, 4'b0001, 64'h1, 64'h0, 5'd1, 1'b1);
        if (idx == 1) send(idx, 4'b0001, 64'h2, 64'h0, 5'd2, 1'b1);
        check("bp_ready_low", in_ready[idx], 1'b0);
        fork
            begin
                if (idx == 1) send(idx, 4'b0001, 64'h3, 64'h0, 5'd3, 1'b1);
                else          send(idx, 4'b0001, 64'h2, 64'h0, 5'd2, 1'b1);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_hold_ready", in_ready[idx], 1'b0);
                check("bp_hold_out", {out_valid[idx], get_out(idx).alu}, {1'b1, 64'h1});
                out_ready[idx] = 1'b1;
            end
        join
        wait_empty(idx);

        // Flush with every entry full
        out_ready[idx] = 1'b0;
        send(idx, 4'b0011, 64'h60, 64'h0, 5'd4, 1'b1);
        if (idx == 1) send(idx, 4'b0011, 64'h61, 64'h0, 5'd6, 1'b1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        clear_sb(idx);
        check("flush_out", {out_valid[idx], mr_m[idx], mtr_m[idx], mw_m[idx], rw_m[idx]}, 5'b0);
        check("flush_ready", in_ready[idx], 1'b1);
        out_ready[idx] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_gone", out_valid[idx], 1'b0);

        // Flush in the same cycle as accepting a store
        {mr_e, mtr_e, mw_e, rw_e} = 4'b0010;
        alu_e = 64'h99;
        in_valid[idx] = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid[idx] = 1'b0;
        flush = 1'b0;
        check("flush_drop", {out_valid[idx], mw_m[idx]}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check("flush_drop_late", {out_valid[idx], mw_m[idx]}, 2'b00);

        // Asynchronous reset during a stall
        out_ready[idx] = 1'b0;
        send(idx, 4'b0001, 64'h70, 64'h71, 5'd3, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_out", {out_valid[idx], get_out(idx)}, '0);
        check("areset_ready", in_ready[idx], 1'b1);
        clear_sb(idx);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready[idx] = 1'b1;
        c0 = cyc;
        send(idx, 4'b0001, 64'h80, 64'h81, 5'd8, 1'b1);
        check("post_reset_lat", {out_valid[idx], get_out(idx).alu}, {1'b1, 64'h80});
        check("post_reset_cycles", cyc - c0, 1);
        wait_empty(idx);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        {mr_e, mtr_e, mw_e, rw_e} = 4'b0;
        alu_e = '0;
        wd_e  = '0;
        wr_e  = '0;
        #3;
        for (int i = 0; i < 2; i++) begin
            check("reset_out", {out_valid[i], get_out(i)}, '0);
            check("reset_ready", in_ready[i], 1'b1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_plan(1);
        run_plan(0);
        check("sb0_empty", sb0.size(), 0);
        check("sb1_empty", sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
